// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, queue entry type and PC helper for the fetch unit
package fetch_pkg;
    localparam int XLEN = 32;
    localparam int INST_W = 32;
    localparam int PC_INCR = 4;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [INST_W-1:0] inst;
    } fq_entry_t;
    function automatic logic [63:0] align_pc(input logic [63:0] pc);
        return {pc[63:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetched entries; flush dominates push/pop
module fetch_queue import fetch_pkg::*; #(
    parameter int DEPTH = 4,
    parameter type T = fq_entry_t
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  T                        wdata,
    output T                        rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);
    T mem [DEPTH];
    logic [AW-1:0] wp, rp;
    assign rdata = mem[rp];
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    always_ff @(posedge clk) if (push) mem[wp] <= wdata;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            wp <= wp + AW'(push);
            rp <= rp + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/fetch_unit_q.sv
// fetch_unit_q: credit-limited sequential fetch with a decode queue, redirect flush and stale-response drop
module fetch_unit_q #(
    parameter int               XLEN     = fetch_pkg::XLEN,
    parameter int               INST_W   = fetch_pkg::INST_W,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               FQ_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              stall_pc,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [XLEN-1:0]   inst_pc,
    output logic [XLEN-1:0]   prev_pc
);
    import fetch_pkg::*;
    localparam int CW = $clog2(FQ_DEPTH) + 1;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;
    logic [XLEN-1:0] fetch_pc, rsp_pc, target;
    logic [CW-1:0] outstanding, drop_cnt, q_count;
    logic credit_ok, req_fire, push, pop, q_full, q_empty;
    entry_t head, wr;
    assign target = XLEN'(align_pc(64'(redirect_pc)));
    assign credit_ok = ({1'b0, q_count} + {1'b0, outstanding}) < (CW+1)'(FQ_DEPTH);
    assign imem_req_valid = credit_ok && !stall_pc && !redirect_valid && !i_rst;
    assign imem_req_addr = fetch_pc;
    assign req_fire = imem_req_valid && imem_req_ready;
    assign push = imem_rsp_valid && drop_cnt == '0 && !redirect_valid && !i_rst;
    assign inst_valid = !q_empty && !redirect_valid && !i_rst;
    assign pop = inst_valid && inst_ready;
    assign inst_data = i_rst ? '0 : head.inst;
    assign inst_pc = i_rst ? '0 : head.pc;
    assign wr = '{pc: rsp_pc, inst: imem_rsp_data};
    fetch_queue #(.DEPTH(FQ_DEPTH), .T(entry_t)) u_fq (
        .clk(i_clk),
        .rst(i_rst),
        .push(push),
        .pop(pop),
        .flush(redirect_valid),
        .wdata(wr),
        .rdata(head),
        .count(q_count),
        .full(q_full),
        .empty(q_empty)
    );
    // a response arriving with a redirect belongs to the old stream, so it is dropped and not counted
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc <= RESET_PC;
            outstanding <= '0;
            drop_cnt <= '0;
            prev_pc <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= target;
            rsp_pc <= target;
            drop_cnt <= outstanding - CW'(imem_rsp_valid);
            outstanding <= outstanding - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + XLEN'(PC_INCR);
            if (push) rsp_pc <= rsp_pc + XLEN'(PC_INCR);
            if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (pop) prev_pc <= inst_pc;
        end
    end
    always_ff @(posedge i_clk) if (!i_rst && !redirect_valid) assert (!(push && q_full && !pop));
endmodule

// File: tb/tb_fetch_unit_q.sv
// tb_fetch_unit_q: directed scenarios against a latency-programmable in-order memory model
module tb_fetch_unit_q;
    logic clk = 0, rst = 1, stall_pc = 0, redirect_valid = 0;
    logic [31:0] redirect_pc = 0;
    logic imem_req_valid, imem_req_ready = 1;
    logic [31:0] imem_req_addr;
    logic imem_rsp_valid = 0;
    logic [31:0] imem_rsp_data = 0;
    logic inst_valid, inst_ready = 1;
    logic [31:0] inst_data, inst_pc, prev_pc;
    int total = 0, bad = 0, lat = 1, cyc = 0;
    logic [31:0] pipe_a[$];
    int pipe_t[$];

    always #5 clk = ~clk;

    fetch_unit_q #(.XLEN(32), .INST_W(32), .RESET_PC(32'h100), .FQ_DEPTH(4)) dut (
        .i_clk(clk), .i_rst(rst), .stall_pc(stall_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_pc(inst_pc), .prev_pc(prev_pc)
    );

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            pipe_a.delete();
            pipe_t.delete();
        end else begin
            if (imem_rsp_valid) begin
                void'(pipe_a.pop_front());
                void'(pipe_t.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                pipe_a.push_back(imem_req_addr);
                pipe_t.push_back(cyc + lat);
            end
        end
        cyc++;
        #1;
        imem_rsp_valid = !rst && pipe_t.size() > 0 && pipe_t[0] <= cyc;
        imem_rsp_data = imem_rsp_valid ? data_of(pipe_a[0]) : '0;
    end

    task automatic do_reset(input int l);
        @(negedge clk);
        rst = 1; stall_pc = 0; redirect_valid = 0; redirect_pc = 0;
        imem_req_ready = 1; inst_ready = 1; lat = l;
        @(negedge clk);
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
        total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL rst_inst_pc: got %h want 0", inst_pc); end
        total++; if (inst_data !== 32'h0) begin bad++; $display("FAIL rst_inst_data: got %h want 0", inst_data); end
        total++; if (prev_pc !== 32'h0) begin bad++; $display("FAIL rst_prev_pc: got %h want 0", prev_pc); end
        @(negedge clk);
        rst = 0;
        #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin bad++; $display("FAIL rst_first_req: got v=%b a=%h want v=1 a=00000100", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] want_pc, want_prev;
        do_reset(1);
        for (int j = 0; j <= 8; j++) begin
            if (j > 0) begin @(negedge clk); #1; end
            total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 + 32'(4 * j)) begin bad++; $display("FAIL seq_req[%0d]: got v=%b a=%h want v=1 a=%h", j, imem_req_valid, imem_req_addr, 32'h100 + 32'(4 * j)); end
            if (j >= 2) begin
                want_pc = 32'h100 + 32'(4 * (j - 2));
                total++; if (inst_valid !== 1'b1 || inst_pc !== want_pc || inst_data !== data_of(want_pc)) begin bad++; $display("FAIL seq_inst[%0d]: got v=%b pc=%h d=%h want v=1 pc=%h d=%h", j, inst_valid, inst_pc, inst_data, want_pc, data_of(want_pc)); end
            end else begin
                total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL seq_early_valid[%0d]: got %b want 0", j, inst_valid); end
            end
            want_prev = (j >= 3) ? 32'h100 + 32'(4 * (j - 3)) : 32'h0;
            total++; if (prev_pc !== want_prev) begin bad++; $display("FAIL seq_prev_pc[%0d]: got %h want %h", j, prev_pc, want_prev); end
        end
    endtask

    task automatic test_backpressure();
        int nreq;
        do_reset(1);
        inst_ready = 0;
        nreq = 0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            if (imem_req_valid && imem_req_ready) nreq++;
        end
        total++; if (nreq !== 4) begin bad++; $display("FAIL bp_req_count: got %0d want 4", nreq); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_req_blocked: got %b want 0", imem_req_valid); end
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin bad++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=00000100", inst_valid, inst_pc); end
        @(negedge clk);
        inst_ready = 1;
        #1;
        total++; if (imem_req_valid !== 1'b0 || inst_pc !== 32'h100) begin bad++; $display("FAIL bp_release0: got v=%b pc=%h want v=0 pc=00000100", imem_req_valid, inst_pc); end
        @(negedge clk); #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h110) begin bad++; $display("FAIL bp_resume_req: got v=%b a=%h want v=1 a=00000110", imem_req_valid, imem_req_addr); end
        total++; if (inst_pc !== 32'h104 || prev_pc !== 32'h100) begin bad++; $display("FAIL bp_resume_inst: got pc=%h prev=%h want pc=00000104 prev=00000100", inst_pc, prev_pc); end
        @(negedge clk); #1;
        total++; if (imem_req_addr !== 32'h114 || inst_pc !== 32'h108) begin bad++; $display("FAIL bp_resume_next: got a=%h pc=%h want a=00000114 pc=00000108", imem_req_addr, inst_pc); end
    endtask

    task automatic test_redirect_drop();
        int nval;
        do_reset(4);
        repeat (3) @(negedge clk);
        redirect_valid = 1;
        redirect_pc = 32'h2003;
        #1;
        total++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL rd_during: got req=%b inst=%b want 0 0", imem_req_valid, inst_valid); end
        @(negedge clk);
        redirect_valid = 0;
        #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h2000) begin bad++; $display("FAIL rd_target_req: got v=%b a=%h want v=1 a=00002000", imem_req_valid, imem_req_addr); end
        nval = 0;
        for (int c = 4; c <= 8; c++) begin
            if (c > 4) begin @(negedge clk); #1; end
            if (inst_valid) nval++;
        end
        total++; if (nval !== 0) begin bad++; $display("FAIL rd_stale_visible: got %0d valid cycles want 0", nval); end
        @(negedge clk); #1;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h2000 || inst_data !== data_of(32'h2000)) begin bad++; $display("FAIL rd_first_inst: got v=%b pc=%h d=%h want v=1 pc=00002000 d=%h", inst_valid, inst_pc, inst_data, data_of(32'h2000)); end
    endtask

    task automatic test_redirect_collide();
        do_reset(2);
        repeat (3) @(negedge clk);
        redirect_valid = 1;
        redirect_pc = 32'h3000;
        #1;
        total++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL rc_during: got inst=%b req=%b want 0 0", inst_valid, imem_req_valid); end
        @(negedge clk);
        redirect_valid = 0;
        #1;
        total++; if (prev_pc !== 32'h0 || inst_valid !== 1'b0) begin bad++; $display("FAIL rc_no_dequeue: got prev=%h v=%b want prev=0 v=0", prev_pc, inst_valid); end
        total++; if (imem_req_addr !== 32'h3000 || imem_req_valid !== 1'b1) begin bad++; $display("FAIL rc_target_req: got v=%b a=%h want v=1 a=00003000", imem_req_valid, imem_req_addr); end
        repeat (2) begin
            @(negedge clk); #1;
            total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rc_stale_visible: got %b want 0", inst_valid); end
        end
        @(negedge clk); #1;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h3000 || inst_data !== data_of(32'h3000)) begin bad++; $display("FAIL rc_first_inst: got v=%b pc=%h d=%h want v=1 pc=00003000 d=%h", inst_valid, inst_pc, inst_data, data_of(32'h3000)); end
        @(negedge clk); #1;
        total++; if (prev_pc !== 32'h3000 || inst_pc !== 32'h3004) begin bad++; $display("FAIL rc_next: got prev=%h pc=%h want prev=00003000 pc=00003004", prev_pc, inst_pc); end
    endtask

    task automatic test_wrap();
        do_reset(1);
        @(negedge clk);
        redirect_valid = 1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 0;
        #1;
        total++; if (imem_req_addr !== 32'hFFFF_FFFC || imem_req_valid !== 1'b1) begin bad++; $display("FAIL wrap_req0: got v=%b a=%h want v=1 a=fffffffc", imem_req_valid, imem_req_addr); end
        @(negedge clk); #1;
        total++; if (imem_req_addr !== 32'h0 || imem_req_valid !== 1'b1) begin bad++; $display("FAIL wrap_req1: got v=%b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr); end
        @(negedge clk); #1;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_inst0: got v=%b pc=%h want v=1 pc=fffffffc", inst_valid, inst_pc); end
        @(negedge clk); #1;
        total++; if (inst_pc !== 32'h0 || inst_data !== data_of(32'h0)) begin bad++; $display("FAIL wrap_inst1: got pc=%h d=%h want pc=00000000 d=%h", inst_pc, inst_data, data_of(32'h0)); end
    endtask

    task automatic test_stall_and_reset();
        int nstall;
        do_reset(2);
        @(negedge clk);
        nstall = 0;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            stall_pc = 1;
            #1;
            if (imem_req_valid) nstall++;
            if (c == 3) begin
                total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin bad++; $display("FAIL st_inst0: got v=%b pc=%h want v=1 pc=00000100", inst_valid, inst_pc); end
            end
            if (c == 4) begin
                total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h104) begin bad++; $display("FAIL st_inst1: got v=%b pc=%h want v=1 pc=00000104", inst_valid, inst_pc); end
            end
            if (c == 5) begin
                total++; if (inst_valid !== 1'b0 || prev_pc !== 32'h104) begin bad++; $display("FAIL st_drained: got v=%b prev=%h want v=0 prev=00000104", inst_valid, prev_pc); end
            end
        end
        total++; if (nstall !== 0) begin bad++; $display("FAIL st_no_req: got %0d requests want 0", nstall); end
        @(negedge clk);
        stall_pc = 0;
        #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h108) begin bad++; $display("FAIL st_resume: got v=%b a=%h want v=1 a=00000108", imem_req_valid, imem_req_addr); end
        @(negedge clk);
        rst = 1;
        #1;
        total++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst_pc !== 32'h0) begin bad++; $display("FAIL st_rst_gate: got req=%b inst=%b pc=%h want 0 0 0", imem_req_valid, inst_valid, inst_pc); end
        @(negedge clk);
        rst = 0;
        #1;
        total++; if (imem_req_addr !== 32'h100 || prev_pc !== 32'h0 || inst_valid !== 1'b0) begin bad++; $display("FAIL st_rst_state: got a=%h prev=%h v=%b want a=00000100 prev=0 v=0", imem_req_addr, prev_pc, inst_valid); end
        repeat (3) @(negedge clk);
        #1;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin bad++; $display("FAIL st_rst_refetch: got v=%b pc=%h want v=1 pc=00000100", inst_valid, inst_pc); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_drop();
        test_redirect_collide();
        test_wrap();
        test_stall_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
